// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - instruction fetch controller: PC -> imem req/ack -> decode valid/ready (optional MISALIGN_CHK_EN)
module instr_fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] pc,
  output logic              load,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              flush,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               imem_req_q, imem_req_d;
  logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
  logic [DATA_W-1:0]  instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
`ifdef MISALIGN_CHK_EN
  logic               fetch_err_q, fetch_err_d;
`endif

  // PC advance strobe: only when decode takes a held instruction and no flush kills it
  assign load = (state_q == VALID) & instr_valid_q & instr_ready & ~flush;

  // Next-state and register updates for the fetch handshake FSM
  always_comb begin
    state_d       = state_q;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fetch_cnt_d   = fetch_cnt_q;
`ifdef MISALIGN_CHK_EN
    fetch_err_d   = fetch_err_q;
`endif
    case (state_q)
      ISSUE: begin
`ifdef MISALIGN_CHK_EN
        if (pc[1:0] != 2'b00) begin
          fetch_err_d = 1'b1;
        end else begin
          imem_addr_d = pc;
          imem_req_d  = 1'b1;
          state_d     = REQ;
        end
`else
        imem_addr_d = pc;
        imem_req_d  = 1'b1;
        state_d     = REQ;
`endif
      end
      REQ: begin
        if (imem_ack) begin
          imem_req_d = 1'b0;
          if (flush) begin
            state_d = ISSUE;
          end else begin
            instr_d       = imem_rdata;
            instr_valid_d = 1'b1;
            state_d       = VALID;
          end
        end else if (flush) begin
          // The outstanding request cannot be retracted; wait out its ack
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          imem_req_d = 1'b0;
          state_d    = ISSUE;
        end
      end
      VALID: begin
        if (flush) begin
          instr_valid_d = 1'b0;
          state_d       = ISSUE;
        end else if (load) begin
          fetch_cnt_d   = fetch_cnt_q + CNT_W'(1);
          instr_valid_d = 1'b0;
          state_d       = ISSUE;
        end
      end
      default: state_d = ISSUE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q       <= ISSUE;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fetch_cnt_q   <= '0;
`ifdef MISALIGN_CHK_EN
      fetch_err_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fetch_cnt_q   <= fetch_cnt_d;
`ifdef MISALIGN_CHK_EN
      fetch_err_q   <= fetch_err_d;
`endif
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign fetch_cnt   = fetch_cnt_q;
`ifdef MISALIGN_CHK_EN
  assign fetch_err   = fetch_err_q;
`else
  assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - self-checking bench for instr_fetch_ctrl
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        areset;
  logic [31:0] pc;
  logic        load;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        flush;
  logic [3:0]  fetch_cnt;
  logic        fetch_err;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int loads   = 0;
  int exp_cnt = 0;
  logic [31:0] exp_q[$];

  instr_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut (
    .clk         (clk),
    .areset      (areset),
    .pc          (pc),
    .load        (load),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .flush       (flush),
    .fetch_cnt   (fetch_cnt),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; the PC model advances when load was high at the edge
  task automatic tick();
    logic pre;
    #1;
    pre = load;
    @(posedge clk);
    #1;
    cyc++;
    if (pre === 1'b1) begin
      pc = pc + 32'd4;
      loads++;
    end
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("req_rise", imem_req, 1'b1);
  endtask

  task automatic fetch(input logic [31:0] data, input int ack_wait, input int rdy_wait,
                       input bit flush_acc, output int req_cyc, output int val_cyc);
    logic [31:0] a;
    wait_req();
    req_cyc = cyc;
    chk("req_addr", imem_addr, pc);
    a = imem_addr;
    repeat (ack_wait) begin
      tick();
      chk("addr_hold", imem_addr, a);
      chk("valid_low_wait", instr_valid, 1'b0);
    end
    imem_ack = 1'b1;
    imem_rdata = data;
    exp_q.push_back(data);
    tick();
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    val_cyc = cyc;
    chk("valid_rise", instr_valid, 1'b1);
    chk("req_fall", imem_req, 1'b0);
    repeat (rdy_wait) begin
      tick();
      chk("instr_hold", instr, data);
      chk("load_idle", load, 1'b0);
    end
    instr_ready = 1'b1;
    flush = flush_acc;
    #1;
    chk("load", load, flush_acc ? 1'b0 : 1'b1);
    if (exp_q.size() > 0) chk("instr", instr, exp_q.pop_front());
    else chk("sb_empty", 32'd0, 32'd1);
    if (!flush_acc) exp_cnt = (exp_cnt + 1) % 16;
    tick();
    instr_ready = 1'b0;
    flush = 1'b0;
    chk("valid_fall", instr_valid, 1'b0);
    chk("load_after", load, 1'b0);
    chk("cnt", fetch_cnt, exp_cnt);
  endtask

  initial begin
    int rc, vc;
    areset = 1'b0;
    pc = 32'd0;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    instr_ready = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_cnt", fetch_cnt, 4'd0);
    chk("rst_err", fetch_err, 1'b0);
    chk("rst_load", load, 1'b0);
    areset = 1'b1;
    cyc = 0;

    // Basic fetch: ack one cycle after request, immediate ready
    fetch(32'h00500093, 1, 0, 1'b0, rc, vc);
    chk("t1_req_cycle", rc, 1);
    chk("t1_valid_cycle", vc, 3);
    chk("t1_cnt", fetch_cnt, 4'd1);

    // Slow memory and slow decode; next request must come from pc=4
    fetch(32'h00A00113, 4, 3, 1'b0, rc, vc);

    // Flush while request outstanding; late DEADBEEF ack must be dropped
    wait_req();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("drain_req", imem_req, 1'b1);
    chk("drain_valid", instr_valid, 1'b0);
    tick();
    chk("drain_req2", imem_req, 1'b1);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    tick();
    imem_ack = 1'b0;
    chk("drain_done_req", imem_req, 1'b0);
    chk("drain_done_valid", instr_valid, 1'b0);
    tick();
    chk("reissue_req", imem_req, 1'b1);
    chk("reissue_addr", imem_addr, pc);
    chk("reissue_valid", instr_valid, 1'b0);
    fetch(32'h00308193, 0, 0, 1'b0, rc, vc);

    // Flush together with ready in VALID: no load, no count
    fetch(32'h00400213, 0, 1, 1'b1, rc, vc);

    // Reset mid-transaction, then a stray ack in ISSUE
    wait_req();
    areset = 1'b0;
    #1;
    chk("midrst_req", imem_req, 1'b0);
    chk("midrst_cnt", fetch_cnt, 4'd0);
    exp_cnt = 0;
    @(posedge clk);
    #1;
    areset = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hBADC0DE0;
    tick();
    imem_ack = 1'b0;
    chk("late_ack_req", imem_req, 1'b1);
    chk("late_ack_valid", instr_valid, 1'b0);
    tick();
    chk("late_ack_valid2", instr_valid, 1'b0);

    // 17 accepted instructions on a 4-bit counter: wraps 15 -> 0, ends at 1
    for (int i = 0; i < 17; i++) begin
      fetch($urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0, rc, vc);
    end
    chk("wrap_final", fetch_cnt, 4'd1);

    // Misaligned PC
    pc = 32'h00000006;
`ifdef MISALIGN_CHK_EN
    tick();
    chk("mis_req", imem_req, 1'b0);
    chk("mis_err", fetch_err, 1'b1);
    tick();
    chk("mis_req2", imem_req, 1'b0);
    pc = 32'h00000008;
    tick();
    chk("mis_resume_req", imem_req, 1'b1);
    chk("mis_resume_addr", imem_addr, 32'h00000008);
    chk("mis_err_sticky", fetch_err, 1'b1);
    fetch(32'h00000013, 0, 0, 1'b0, rc, vc);
    chk("mis_err_sticky2", fetch_err, 1'b1);
`else
    tick();
    chk("nochk_req", imem_req, 1'b1);
    chk("nochk_addr", imem_addr, 32'h00000006);
    chk("nochk_err", fetch_err, 1'b0);
    fetch(32'h00000013, 0, 0, 1'b0, rc, vc);
`endif

    chk("loads_total", loads, 21);
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
